// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and timing constants for the button conditioner
package button_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;
  localparam int DEF_STABLE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 10_000_000;
  localparam int DEF_CNT_W         = 26;
  localparam int SIM_STABLE = 4;
  localparam int SIM_DELAY  = 10;
  localparam int SIM_PERIOD = 3;
endpackage

// File: rtl/button_conditioner_repeat_timer.sv
// repeat_timer: auto-repeat interval timer, first interval DELAY then PERIOD
module repeat_timer
  import button_pkg::*;
#(
  parameter int REPEAT_EN = 1,
  parameter int DELAY     = DEF_REPEAT_DELAY,
  parameter int PERIOD    = DEF_REPEAT_PERIOD,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);
  logic [CNT_W-1:0] hold_cnt;
  logic             first;
  logic             hit;
  assign hit = hold_cnt == (first ? CNT_W'(DELAY - 1) : CNT_W'(PERIOD - 1));
  // count held cycles; idle cycles park the counter at zero, clear arms the long first interval
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      first    <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick     <= run && hit && (REPEAT_EN != 0);
      hold_cnt <= (!run || hit) ? '0 : hold_cnt + 1'b1;
      first    <= clear ? 1'b1 : (run && hit) ? 1'b0 : first;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounce a synchronized button and emit press/release/repeat pulses
module button_conditioner
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sigi,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);
  btn_state_t       state, state_n;
  logic [CNT_W-1:0] stab_cnt, stab_n;
  logic             level_n, press_n, release_n;
  logic             stab_done, run;
  assign stab_done = stab_cnt == CNT_W'(STABLE_CYCLES - 1);
  assign run       = (state == PRESSED) && sigi;
  // debounce next-state: a change is accepted after STABLE_CYCLES matching samples
  always_comb begin
    state_n   = state;
    stab_n    = stab_cnt;
    level_n   = level;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: if (sigi) begin
        state_n = PRESS_WAIT;
        stab_n  = CNT_W'(1);
      end
      PRESS_WAIT: if (!sigi) begin
        state_n = IDLE;
        stab_n  = '0;
      end else if (stab_done) begin
        state_n = PRESSED;
        stab_n  = '0;
        level_n = 1'b1;
        press_n = 1'b1;
      end else stab_n = stab_cnt + 1'b1;
      PRESSED: if (!sigi) begin
        state_n = RELEASE_WAIT;
        stab_n  = CNT_W'(1);
      end
      RELEASE_WAIT: if (sigi) begin
        state_n = PRESSED;
        stab_n  = '0;
      end else if (stab_done) begin
        state_n   = IDLE;
        stab_n    = '0;
        level_n   = 1'b0;
        release_n = 1'b1;
      end else stab_n = stab_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stab_cnt      <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      stab_cnt      <= stab_n;
      level         <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
    end
  end
  repeat_timer #(
    .REPEAT_EN(REPEAT_EN),
    .DELAY    (REPEAT_DELAY),
    .PERIOD   (REPEAT_PERIOD),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clear(press_n),
    .tick (repeat_pulse)
  );
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomized and directed checks against a sample-history model
module tb_button_conditioner;
  import button_pkg::*;
  localparam int N = SIM_STABLE;
  localparam int D = SIM_DELAY;
  localparam int P = SIM_PERIOD;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sigi = 1'b0;
  logic lv, pp, rp, tp, lv0, pp0, rp0, tp0;
  always #5 clk = ~clk;
  button_conditioner #(.STABLE_CYCLES(N), .REPEAT_EN(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .sigi(sigi), .level(lv), .press_pulse(pp), .release_pulse(rp), .repeat_pulse(tp));
  button_conditioner #(.STABLE_CYCLES(N), .REPEAT_EN(0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(W)) dut_n (
    .clk(clk), .rst(rst), .sigi(sigi), .level(lv0), .press_pulse(pp0), .release_pulse(rp0), .repeat_pulse(tp0));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0d got %b want %b", nm, t, a, e);
    end
  endtask
  // model: level flips when the last N samples since the previous change/reset all disagree with it;
  // repeats fire when the edge distance from the last reference point reaches DELAY (first) or PERIOD
  int t = 0;
  int since = 0;
  int ref_t = 0;
  int rst_t = -1;
  bit first = 0;
  bit hist [0:32767];
  bit e_lv = 0, e_pp = 0, e_rp = 0, e_tp = 0;
  always @(posedge clk) begin
    bit ok;
    t++;
    hist[t] = sigi;
    e_pp = 0;
    e_rp = 0;
    e_tp = 0;
    if (rst) begin
      e_lv = 0;
      since = t;
      first = 0;
      rst_t = t;
    end else begin
      ok = (t - since) >= N;
      if (ok) for (int k = 0; k < N; k++) if (hist[t-k] == e_lv) ok = 0;
      if (ok) begin
        e_lv = !e_lv;
        since = t;
        if (e_lv) begin
          e_pp = 1;
          ref_t = t;
          first = 1;
        end else e_rp = 1;
      end else if (e_lv && sigi) begin
        if (!hist[t-1]) ref_t = t;
        else if (t - ref_t == (first ? D : P)) begin
          e_tp = 1;
          ref_t = t;
          first = 0;
        end
      end
    end
  end
  int last_ev = 0;
  int press_t = 0;
  int pcount = 0;
  int rcount = 0;
  int reps[$];
  always @(negedge clk) if (t > 0) begin
    chk("level", lv, e_lv);
    chk("press", pp, e_pp);
    chk("release", rp, e_rp);
    chk("repeat", tp, e_tp);
    chk("level_norep", lv0, e_lv);
    chk("press_norep", pp0, e_pp);
    chk("release_norep", rp0, e_rp);
    chk("repeat_off", tp0, 1'b0);
    chk("one_pulse", (int'(pp) + int'(rp) + int'(tp)) <= 1, 1'b1);
    if (rst_t == t) last_ev = 0;
    if (pp) begin
      chk("alt_press", last_ev == 0, 1'b1);
      last_ev = 1;
      press_t = t;
      pcount++;
    end
    if (rp) begin
      chk("alt_release", last_ev == 1, 1'b1);
      last_ev = 0;
      rcount++;
    end
    if (tp) reps.push_back(t - press_t);
  end
  task automatic step(input logic s, input logic r = 1'b0);
    @(negedge clk);
    sigi = s;
    rst = r;
  endtask
  initial begin
    int exp_r[5];
    int pc, rc, cyc, len;
    logic v;
    exp_r = '{10, 13, 16, 19, 22};
    repeat (3) step(0, 1);
    step(0);
    chk("rst_level", lv, 1'b0);
    chk("rst_press", pp, 1'b0);
    // clean press and auto-repeat
    reps.delete();
    repeat (4) step(1);
    step(1);
    chk("clean_press", pp, 1'b1);
    chk("clean_level", lv, 1'b1);
    chk("model_press", e_pp, 1'b1);
    step(1);
    chk("clean_press_end", pp, 1'b0);
    chk("clean_level_hold", lv, 1'b1);
    repeat (24) step(1);
    chk("rep_count", reps.size() >= 5, 1'b1);
    if (reps.size() >= 5) for (int i = 0; i < 5; i++) chk("rep_offset", reps[i] == exp_r[i], 1'b1);
    // release glitch then real release
    rc = rcount;
    repeat (2) step(0);
    repeat (6) step(1);
    chk("glitch_level", lv, 1'b1);
    chk("glitch_norel", rcount == rc, 1'b1);
    repeat (4) step(0);
    step(0);
    chk("release_pulse", rp, 1'b1);
    chk("model_release", e_rp, 1'b1);
    step(0);
    chk("release_level", lv, 1'b0);
    // bounce from idle
    pc = pcount;
    step(1); step(1); step(1); step(0); step(1); step(1); step(1); step(0);
    step(0);
    chk("bounce_level", lv, 1'b0);
    chk("bounce_nopress", pcount == pc, 1'b1);
    // reset during press-wait with the button held
    step(1); step(1);
    step(1, 1);
    step(1);
    chk("midrst_level", lv, 1'b0);
    chk("midrst_press", pp, 1'b0);
    repeat (3) step(1);
    step(1);
    chk("midrst_accept", pp, 1'b1);
    chk("model_midrst", e_lv, 1'b1);
    // randomized runs
    cyc = 0;
    while (cyc < 10000) begin
      v = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 40)) : int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        step(v, $urandom_range(0, 2999) == 0);
        cyc++;
      end
    end
    step(0);
    step(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Debounces a synchronized push-button level and turns it into clean control events for the sequential signed multiplier's front panel. It sits directly downstream of the two-flop input synchronizer and consumes its `sigi` output. It produces a debounced level, one-cycle press and release pulses, and optional auto-repeat pulses. The multiplier control FSM and the operand-entry logic consume these events.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1_000_000: consecutive identical samples needed to accept a change (10 ms at 100 MHz). Must be ≥ 2.
- `REPEAT_EN`, default 1: 1 enables auto-repeat; 0 holds `repeat_pulse` at 0.
- `REPEAT_DELAY`, default 50_000_000: cycles in PRESSED before the first repeat pulse. Must be ≥ 1.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeat pulses. Must be ≥ 1.
- `CNT_W`, default 26: counter width. Requires 2^CNT_W > max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `sigi` input 1: synchronized raw button level from the synchronizer.
- `level` output 1: debounced button state, registered.
- `press_pulse` output 1: one-cycle pulse when a press is accepted.
- `release_pulse` output 1: one-cycle pulse when a release is accepted.
- `repeat_pulse` output 1: one-cycle auto-repeat pulse while held.

## Operation
States: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. There are two counters:
- `stab_cnt` counts consecutive samples that differ from `level`.
- `hold_cnt` times auto-repeat.

Transitions:
- **IDLE**: `sigi`=1 → PRESS_WAIT with `stab_cnt`=1. Otherwise stay.
- **PRESS_WAIT**:
  - `sigi`=0 → IDLE with `stab_cnt`=0. No pulse.
  - `sigi`=1 and `stab_cnt`==STABLE_CYCLES-1 → PRESSED. Set `level`=1, `press_pulse`=1, `stab_cnt`=0, `hold_cnt`=0, `first`=1.
  - Otherwise increment `stab_cnt`.
- **PRESSED**:
  - `sigi`=0 → RELEASE_WAIT with `stab_cnt`=1.
  - Otherwise increment `hold_cnt`. The limit is REPEAT_DELAY-1 while `first`=1, else REPEAT_PERIOD-1.
  - On reaching the limit with REPEAT_EN=1: set `repeat_pulse`=1, `hold_cnt`=0, `first`=0.
- **RELEASE_WAIT**:
  - `sigi`=1 → PRESSED. Set `stab_cnt`=0 and `hold_cnt`=0, but keep `first` unchanged. No press pulse; `level` stays 1.
  - `sigi`=0 and `stab_cnt`==STABLE_CYCLES-1 → IDLE. Set `level`=0, `release_pulse`=1, `stab_cnt`=0.
  - Otherwise increment `stab_cnt`.
- `hold_cnt` does not advance in RELEASE_WAIT, so no repeat pulse can fire there.
- All pulses are registered. Each pulse is high for exactly one cycle, then returns to 0.
- `press_pulse`, `release_pulse` and `repeat_pulse` are mutually exclusive in any cycle.

## Timing
- Reset values: state=IDLE, `level`=0, all pulses 0, all counters 0, `first`=0.
- Reset is sampled only on a `clk` edge. It overrides every transition. If `rst` is asserted mid-operation, the block is in IDLE after that edge with no pulse emitted.
- After reset, a button already held needs a full STABLE_CYCLES run before `press_pulse` fires.
- Press latency: if `sigi` is sampled 1 on edges E1..EN (N=STABLE_CYCLES) after IDLE, `level` and `press_pulse` become 1 after edge EN. Release latency mirrors this from PRESSED.
- A glitch of 1..N-1 samples produces no output change.
- First repeat pulse: REPEAT_DELAY edges after the press-accept edge. Later repeat pulses follow every REPEAT_PERIOD edges.
- Counters never wrap; they are cleared at each limit or state change.

## Structure
- Package `button_pkg`:
  - state enum `btn_state_t` (2-bit: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3);
  - default timing constants;
  - a simulation constant set: STABLE=4, DELAY=10, PERIOD=3.
- Sub-module `repeat_timer` (inputs `clk`, `rst`, `run`, `clear`; output `tick`) holds `hold_cnt` and `first`. The debounce FSM stays in `button_conditioner`.

## Test plan
All scenarios use STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- **Clean press:** `sigi` rises and holds → `press_pulse` high for exactly 1 cycle after the 4th high sample. `level`=1 from the same cycle.
- **Bounce:** `sigi` pattern 1,1,1,0,1,1,1,0 from IDLE → no pulse, `level` stays 0.
- **Release glitch:** in PRESSED, `sigi` drops for 2 cycles then returns → no `release_pulse`, `level` stays 1. A 4-cycle drop → one `release_pulse`, then `level`=0.
- **Auto-repeat:** hold for 25 cycles after press-accept → `repeat_pulse` at +10, +13, +16, +19, +22. With REPEAT_EN=0 → none.
- **Reset mid-press:** assert `rst` for 1 cycle during PRESS_WAIT (`stab_cnt`=2) with `sigi` held at 1 → outputs 0, and the press is accepted 4 samples after `rst` deasserts.
- **Exclusivity:** random `sigi` for 10k cycles → never more than one pulse per cycle. Press and release pulses alternate, starting with a press.
